// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states
// and the byte-enable helper used by the lane aligner.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << offset;
      SIZE_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data replication and byte enables,
// load lane extraction with sign/zero extension, alignment and size checks.
module lsu_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wdata_rep,
  output logic [3:0]  byte_en,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal_size
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    wdata_rep = store_data;
    case (size)
      SIZE_BYTE: wdata_rep = {4{store_data[7:0]}};
      SIZE_HALF: wdata_rep = {2{store_data[15:0]}};
      default:   wdata_rep = store_data;
    endcase

    byte_en      = byte_mask(size, offset);
    misaligned   = ((size == SIZE_HALF) && offset[0]) ||
                   ((size == SIZE_WORD) && (offset != 2'b00));
    illegal_size = (size == SIZE_ILL);

    byte_shift = load_word >> {offset, 3'b000};
    half_shift = load_word >> {offset[1], 4'b0000};
    lane_b     = byte_shift[7:0];
    lane_h     = half_shift[15:0];

    load_data = load_word;
    case (size)
      SIZE_BYTE: load_data = is_unsigned ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
      SIZE_HALF: load_data = is_unsigned ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
      default:   load_data = load_word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder over a word array with a
// programmable response latency and a valid/ready response channel.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned     IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * 4);

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              range_err;
  logic              req_err;
  logic [31:0]       wdata_rep;
  logic [3:0]        byte_en;
  logic [31:0]       load_data;
  logic              misaligned;
  logic              illegal_size;

  assign idx       = req_addr[IDX_W+1:2];
  assign req_ready = reset && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid && req_ready;
  assign range_err = ({1'b0, req_addr} >= LIMIT);
  assign req_err   = range_err || misaligned || illegal_size;

  lsu_lane_align u_align (
    .size         (req_size),
    .offset       (req_addr[1:0]),
    .is_unsigned  (req_unsigned),
    .store_data   (req_wdata),
    .load_word    (mem[idx]),
    .wdata_rep    (wdata_rep),
    .byte_en      (byte_en),
    .load_data    (load_data),
    .misaligned   (misaligned),
    .illegal_size (illegal_size)
  );

  // Array has no reset; stores commit at the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        err_q   <= req_err;
        rdata_q <= (req_err || req_we) ? '0 : load_data;
      end
    end
  end

  // BUSY leaves on the edge where the counter reaches zero, so rsp_valid
  // is seen exactly LATENCY edges after acceptance.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY > 1) begin
            state_n = BUSY;
            cnt_n   = 4'(LATENCY - 1);
          end else begin
            state_n = RESP;
          end
        end
      end
      BUSY: begin
        cnt_n = cnt - 4'd1;
        if (cnt_n == 4'd0) state_n = RESP;
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-addressed reference
// memory, plus directed reset, error, backpressure and abort scenarios.
module tb_dmem_responder;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned ADDR_W  = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  ref_mem [DEPTH*4];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: memory as bytes, size as a byte count, alignment by modulo.
  function automatic void model(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input bit uns,
                                output bit err, output logic [31:0] rdata);
    int unsigned n = 1 << size;
    rdata = '0;
    err = (size == 2'b11) || (addr >= DEPTH * 4);
    if (!err) err = (addr % n) != 0;
    if (err) return;
    if (we) begin
      for (int unsigned i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
    end else begin
      for (int unsigned i = 0; i < n; i++) rdata[8*i +: 8] = ref_mem[addr + i];
      if (!uns && n < 4 && rdata[8*n-1])
        for (int unsigned i = n; i < 4; i++) rdata[8*i +: 8] = 8'hFF;
    end
  endfunction

  task automatic scramble();
    req_we       = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
  endtask

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input bit uns, input int unsigned hold,
                        input string tag);
    bit          eerr;
    logic [31:0] erd;
    logic [31:0] held;
    int unsigned k;
    model(we, addr, wdata, size, uns, eerr, erd);
    @(negedge clk);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    rsp_ready    = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_valid && k <= 20);
    check({tag, ".latency"}, k, LATENCY);
    check({tag, ".rdata"}, rsp_rdata, erd);
    check({tag, ".err"}, 32'(rsp_err), 32'(eerr));
    held = rsp_rdata;
    repeat (hold) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".hold_rdata"}, rsp_rdata, held);
      check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
      scramble();
      req_valid = 1'b1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".post_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".post_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;

    // Reset held for three cycles
    repeat (3) begin
      @(negedge clk);
      check("rst.req_ready", 32'(req_ready), 32'd0);
      check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst.rsp_err", 32'(rsp_err), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("rel.req_ready", 32'(req_ready), 32'd1);
    check("rel.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rel.rsp_err", 32'(rsp_err), 32'd0);
    check("rel.rsp_rdata", rsp_rdata, 32'd0);

    for (int unsigned w = 0; w < DEPTH; w++)
      do_req(1'b1, 32'(w * 4), $urandom, 2'b10, 1'b0, 0, "init");

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, "st_word");
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, "ld_word");
    check("ld_word.direct", rsp_rdata, 32'hDEADBEEF);

    do_req(1'b1, 32'h10, 32'h11223344, 2'b10, 1'b0, 0, "st_word2");
    do_req(1'b1, 32'h13, 32'hAAAAAA80, 2'b00, 1'b0, 0, "st_byte");
    do_req(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, "ld_sbyte");
    check("ld_sbyte.direct", rsp_rdata, 32'hFFFFFF80);
    do_req(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, "ld_ubyte");
    check("ld_ubyte.direct", rsp_rdata, 32'h00000080);
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b1, 0, "ld_word3");
    check("ld_word3.direct", rsp_rdata, 32'h80223344);

    do_req(1'b1, 32'h00, 32'hCAFEF00D, 2'b10, 1'b0, 0, "st_base");
    do_req(1'b0, 32'h12, 32'h0, 2'b10, 1'b0, 0, "err_misw");
    do_req(1'b1, 32'h01, 32'h5555, 2'b01, 1'b0, 0, "err_mish");
    do_req(1'b1, 32'h00, 32'h12345678, 2'b11, 1'b0, 0, "err_size");
    do_req(1'b0, 32'h00, 32'h0, 2'b10, 1'b0, 0, "ld_base");
    check("ld_base.direct", rsp_rdata, 32'hCAFEF00D);
    do_req(1'b1, 32'(DEPTH * 4 - 4), 32'h0BADCAFE, 2'b10, 1'b0, 0, "st_last");
    do_req(1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, 2'b10, 1'b0, 0, "err_range");
    do_req(1'b0, 32'(DEPTH * 4 - 2), 32'h0, 2'b01, 1'b0, 0, "ld_last_h");

    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, "backpr");

    // Abort a load in BUSY with reset
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("abort.rst_valid", 32'(rsp_valid), 32'd0);
    end
    reset = 1'b1;
    repeat (LATENCY + 3) begin
      @(negedge clk);
      check("abort.no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, "after_abort");

    for (int unsigned t = 0; t < 300; t++) begin
      we   = 1'($urandom);
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 7));
      do_req(we, addr, $urandom, size, 1'($urandom),
             ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the core's load/store path.
- Accepts one load or store request at a time from the datapath side: address from the ALU result, store data from the register-file second operand.
- Performs size-aware byte-lane writes and sign- or zero-extended reads on an internal word array.
- Returns the read data, or a store acknowledge, after a programmable latency over a valid/ready response channel.

Parameters:
- DEPTH, 256, number of 32-bit words in the array; power of two, minimum 4.
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.
- ADDR_W, 32, request address width in bits (byte address).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising clk edge resets the block.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; LSBs are used for byte and half stores.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal-size request.

Behaviour:
- Reset values: req_ready=0 during the reset cycle and 1 afterwards; rsp_valid=0; rsp_rdata=0; rsp_err=0; state=IDLE; counter=0. Array contents are NOT reset.
- States and transitions:
  - IDLE: req_ready=1. req_valid&&req_ready at edge T accepts the request. Next state is BUSY with counter=LATENCY-1 if LATENCY>1, otherwise RESP.
  - BUSY: req_ready=0. The counter decrements each cycle; at counter==0 → RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err hold stable while rsp_ready=0. rsp_valid&&rsp_ready → IDLE. req_ready stays 0 in RESP; no back-to-back overlap.
- Latency: rsp_valid rises exactly LATENCY cycles after the acceptance edge, with rsp_ready held high.
- Error checks, evaluated at acceptance:
  - misaligned: half with addr[0]!=0, or word with addr[1:0]!=0;
  - out-of-range: addr >= DEPTH*4;
  - illegal size: req_size==11.
- On any error: no array write, rsp_err=1, rsp_rdata=0.
- Store: committed at the acceptance edge using byte enables derived from size and addr[1:0]. Unselected bytes are unchanged. Word index = addr[log2(DEPTH)+1:2]. Response has rsp_rdata=0, rsp_err=0.
- Load: the word is sampled at the acceptance edge and the selected byte/half is extracted by addr[1:0]. Extension follows req_unsigned. Word loads ignore req_unsigned.
- Inputs other than req_valid are don't-care outside the acceptance cycle. Request fields are latched internally; changing inputs in BUSY or RESP has no effect.
- Reset mid-operation: reset==0 in BUSY or RESP aborts the transaction with no response. A store already committed at acceptance stays committed.
- rsp_valid never drops without a handshake except on reset.

Decomposition:
- Shared package dmem_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_ILL localparams;
  - state encoding IDLE=2'd0, BUSY=2'd1, RESP=2'd2;
  - the function computing the byte-enable mask.
- One natural sub-module: lsu_lane_align, combinational. It contains:
  - store byte-lane replication plus 4-bit byte-enable generation;
  - load lane extraction plus sign/zero extension;
  - misalignment and illegal-size flagging.
- The FSM, counter and array stay in dmem_responder.

Test Plan:
1. Reset held low 3 cycles, then released → req_ready=1 on the first cycle after release; rsp_valid=0, rsp_err=0 throughout.
2. Store word 0xDEADBEEF at 0x10, then load word at 0x10, LATENCY=2, rsp_ready=1 → store ack after 2 cycles with rsp_rdata=0, err=0; load returns 0xDEADBEEF exactly 2 cycles after its acceptance.
3. Store byte 0x80 at 0x13 (word previously 0x11223344), then three loads:
   - signed byte at 0x13 → 0xFFFFFF80;
   - unsigned byte at 0x13 → 0x00000080;
   - word at 0x10 → 0x80223344.
4. Word load at 0x12, half store at 0x01, and size=11 at 0x00 → each gives rsp_err=1, rsp_rdata=0. A follow-up word load at 0x00 shows memory unchanged.
5. Load with rsp_ready=0 for 5 cycles after rsp_valid rises → rsp_valid and rsp_rdata stable; req_ready=0 and a new req_valid is ignored. Raising rsp_ready → one handshake, then IDLE with req_ready=1.
6. Accept a load, assert reset==0 one cycle later in BUSY → rsp_valid never rises; after release, req_ready=1 and a new load completes normally.
